lane_reorder_ctrl: RTL and testbench

- Sequences the lane-reorder datapath on the RX side of the 100GbE PCS.
- Inputs: the logical lane ID found by alignment-marker lock on each physical lane.
- Serially builds the inverse map, giving for each logical lane the physical lane that carries it, and checks the map is a valid permutation.
- Delivers the selector bus plus a one-cycle load strobe to the lane-swap/serializer mux. Re-arms automatically on loss of lock.

---
 rtl/lane_reorder_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lane_reorder_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_reorder_ctrl.sv
// rtl/lane_reorder_ctrl.sv - RX PCS lane-reorder sequencer building the logical-to-physical selector map
//
// Ports:
//   i_clock          clock
//   i_reset          synchronous, active-high reset
//   i_enable         block enable; low returns to IDLE and holds outputs
//   i_am_lock        per-physical-lane AM lock, MSB = physical lane 0
//   i_phy_lane_ids   logical ID per physical lane, {phy_0,...,phy_N-1}
//   o_lane_ids       physical-lane selector per logical lane, {sel_log_0,...,sel_log_N-1}
//   o_reorder_done   one-cycle strobe when a new valid map is loaded
//   o_reorder_ok     level, map valid and in use
//   o_dup_error      level, a logical ID was reported by more than one physical lane
//   o_range_error    level, a reported ID is >= N_LANES
//   o_missing_error  level, some logical ID was not reported
module lane_reorder_ctrl #(
  parameter int N_LANES   = 20,
  parameter int NB_ID     = $clog2(N_LANES),
  parameter int NB_ID_BUS = NB_ID * N_LANES
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [N_LANES-1:0]   i_am_lock,
  input  logic [NB_ID_BUS-1:0] i_phy_lane_ids,
  output logic [NB_ID_BUS-1:0] o_lane_ids,
  output logic                 o_reorder_done,
  output logic                 o_reorder_ok,
  output logic                 o_dup_error,
  output logic                 o_range_error,
  output logic                 o_missing_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [NB_ID-1:0] CNT_LAST = NB_ID'(N_LANES - 1);
  // One bit wider than an ID so N_LANES itself is representable for the range compare.
  localparam logic [NB_ID:0]   ID_LIMIT = (NB_ID + 1)'(N_LANES);

  state_t state_q, state_d;

  // Packed arrays are indexed so that element [N_LANES-1-k] is entry k,
  // matching the MSB-first bus ordering of both the input and the output.
  logic [N_LANES-1:0][NB_ID-1:0] shadow_q, shadow_d;
  logic [N_LANES-1:0][NB_ID-1:0] table_q, table_d;
  logic [N_LANES-1:0][NB_ID-1:0] lane_ids_q, lane_ids_d;
  logic [N_LANES-1:0]            seen_q, seen_d;
  logic [NB_ID-1:0]              cnt_q, cnt_d;
  logic                          range_q, range_d;
  logic                          dup_q, dup_d;
  logic                          done_q, done_d;
  logic                          ok_q, ok_d;
  logic                          dup_err_q, dup_err_d;
  logic                          range_err_q, range_err_d;
  logic                          miss_err_q, miss_err_d;

  logic                          start;
  logic [NB_ID-1:0]              cur_id;
  logic                          id_in_range;
  logic [NB_ID-1:0]              slot;
  logic                          missing;
  logic                          map_err;

  // Running requires enable and lock on every lane; losing either aborts or re-arms.
  assign start       = i_enable && (&i_am_lock);
  assign cur_id      = shadow_q[CNT_LAST - cnt_q];
  assign id_in_range = ({1'b0, cur_id} < ID_LIMIT);
  assign slot        = CNT_LAST - cur_id;
  assign missing     = ~(&seen_q);
  assign map_err     = range_q || dup_q || missing;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      table_q     <= '0;
      lane_ids_q  <= '0;
      seen_q      <= '0;
      cnt_q       <= '0;
      range_q     <= 1'b0;
      dup_q       <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      dup_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      miss_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      table_q     <= table_d;
      lane_ids_q  <= lane_ids_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      range_q     <= range_d;
      dup_q       <= dup_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      dup_err_q   <= dup_err_d;
      range_err_q <= range_err_d;
      miss_err_q  <= miss_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_BUILD;
      ST_BUILD: begin
        if (!start)                 state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!start)       state_d = ST_IDLE;
        else if (map_err) state_d = ST_ERROR;
        else              state_d = ST_DONE;
      end
      ST_DONE:  if (!start) state_d = ST_IDLE;
      ST_ERROR: if (!start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d    = shadow_q;
    table_d     = table_q;
    lane_ids_d  = lane_ids_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    range_d     = range_q;
    dup_d       = dup_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    dup_err_d   = dup_err_q;
    range_err_d = range_err_q;
    miss_err_d  = miss_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = i_phy_lane_ids;
          seen_d   = '0;
          cnt_d    = '0;
          range_d  = 1'b0;
          dup_d    = 1'b0;
        end
      end
      ST_BUILD: begin
        if (start) begin
          // First writer of a logical ID wins; later claimants only flag a duplicate.
          if (!id_in_range) begin
            range_d = 1'b1;
          end else if (seen_q[slot]) begin
            dup_d = 1'b1;
          end else begin
            table_d[slot] = cnt_q;
            seen_d[slot]  = 1'b1;
          end
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + NB_ID'(1);
        end
      end
      ST_CHECK: begin
        if (start) begin
          if (!map_err) begin
            lane_ids_d = table_q;
            done_d     = 1'b1;
            ok_d       = 1'b1;
          end else begin
            dup_err_d   = dup_q;
            range_err_d = range_q;
            miss_err_d  = missing;
          end
        end
      end
      ST_DONE: begin
        if (!start) ok_d = 1'b0;
      end
      ST_ERROR: begin
        if (!start) begin
          dup_err_d   = 1'b0;
          range_err_d = 1'b0;
          miss_err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_lane_ids      = lane_ids_q;
  assign o_reorder_done  = done_q;
  assign o_reorder_ok    = ok_q;
  assign o_dup_error     = dup_err_q;
  assign o_range_error   = range_err_q;
  assign o_missing_error = miss_err_q;

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// tb/tb_lane_reorder_ctrl.sv - self-checking bench for lane_reorder_ctrl at 4 and 20 lanes
module tb_lane_reorder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, en4;
  logic [3:0]  lock4;
  logic [7:0]  ids4, lane4;
  logic        done4, ok4, dup4, rng4, miss4;

  logic        rst20, en20;
  logic [19:0] lock20;
  logic [99:0] ids20, lane20;
  logic        done20, ok20, dup20, rng20, miss20;

  lane_reorder_ctrl #(.N_LANES(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst4), .i_enable(en4), .i_am_lock(lock4),
    .i_phy_lane_ids(ids4), .o_lane_ids(lane4), .o_reorder_done(done4),
    .o_reorder_ok(ok4), .o_dup_error(dup4), .o_range_error(rng4),
    .o_missing_error(miss4)
  );

  lane_reorder_ctrl #(.N_LANES(20)) u_dut20 (
    .i_clock(clk), .i_reset(rst20), .i_enable(en20), .i_am_lock(lock20),
    .i_phy_lane_ids(ids20), .o_lane_ids(lane20), .o_reorder_done(done20),
    .o_reorder_ok(ok20), .o_dup_error(dup20), .o_range_error(rng20),
    .o_missing_error(miss20)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a start evaluates the whole snapshot at once and then just waits
  // out the build latency before publishing; 0 idle, 1 waiting, 2 holding result.
  int m_mode[2];
  int m_cd[2];
  bit m_done[2], m_ok[2], m_dup[2], m_rng[2], m_miss[2];
  int m_sel[2][20];
  int p_sel[2][20];
  bit p_dup[2], p_rng[2], p_miss[2];

  task automatic model_step(input int k, input int n, input int nb, input bit rst,
                            input bit go, input logic [99:0] bus);
    bit seen[20];
    int id;
    if (rst) begin
      m_mode[k] = 0; m_cd[k] = 0;
      m_done[k] = 0; m_ok[k] = 0; m_dup[k] = 0; m_rng[k] = 0; m_miss[k] = 0;
      for (int l = 0; l < 20; l++) m_sel[k][l] = 0;
      return;
    end
    m_done[k] = 0;
    case (m_mode[k])
      0: if (go) begin
        for (int l = 0; l < 20; l++) seen[l] = 0;
        p_dup[k] = 0; p_rng[k] = 0; p_miss[k] = 0;
        for (int p = 0; p < n; p++) begin
          id = 0;
          for (int b = 0; b < nb; b++) id += int'(bus[(n-1-p)*nb + b]) << b;
          if (id >= n) p_rng[k] = 1;
          else if (seen[id]) p_dup[k] = 1;
          else begin seen[id] = 1; p_sel[k][id] = p; end
        end
        for (int l = 0; l < n; l++) if (!seen[l]) p_miss[k] = 1;
        m_cd[k] = n + 1;
        m_mode[k] = 1;
      end
      1: if (!go) begin
        m_mode[k] = 0;
        m_cd[k] = 0;
      end else begin
        m_cd[k]--;
        if (m_cd[k] == 0) begin
          m_mode[k] = 2;
          if (!(p_dup[k] || p_rng[k] || p_miss[k])) begin
            for (int l = 0; l < n; l++) m_sel[k][l] = p_sel[k][l];
            m_done[k] = 1;
            m_ok[k] = 1;
          end else begin
            m_dup[k] = p_dup[k]; m_rng[k] = p_rng[k]; m_miss[k] = p_miss[k];
          end
        end
      end
      default: if (!go) begin
        m_ok[k] = 0; m_dup[k] = 0; m_rng[k] = 0; m_miss[k] = 0;
        m_mode[k] = 0;
      end
    endcase
  endtask

  function automatic logic [99:0] sel_bus(input int k, input int n, input int nb);
    logic [99:0] r;
    r = '0;
    for (int l = 0; l < n; l++)
      for (int b = 0; b < nb; b++) r[(n-1-l)*nb + b] = m_sel[k][l][b];
    return r;
  endfunction

  always @(posedge clk) begin
    model_step(0, 4, 2, rst4, en4 && (&lock4), {92'b0, ids4});
    model_step(1, 20, 5, rst20, en20 && (&lock20), ids20);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d4 done", done4, m_done[0]);
      chk("d4 ok", ok4, m_ok[0]);
      chk("d4 dup", dup4, m_dup[0]);
      chk("d4 range", rng4, m_rng[0]);
      chk("d4 missing", miss4, m_miss[0]);
      chk("d4 lane_ids", {92'b0, lane4}, sel_bus(0, 4, 2));
      chk("d20 done", done20, m_done[1]);
      chk("d20 ok", ok20, m_ok[1]);
      chk("d20 dup", dup20, m_dup[1]);
      chk("d20 range", rng20, m_rng[1]);
      chk("d20 missing", miss20, m_miss[1]);
      chk("d20 lane_ids", lane20, sel_bus(1, 20, 5));
    end
  end

  logic [99:0] id_bus;

  initial begin
    rst4 = 1; rst20 = 1; en4 = 0; en20 = 0;
    lock4 = '0; lock20 = '0; ids4 = '0; ids20 = '0;
    id_bus = '0;
    for (int p = 0; p < 20; p++) id_bus[(19-p)*5 +: 5] = 5'(p);
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset d4 outputs", {lane4, done4, ok4, dup4, rng4, miss4}, '0);
    chk("reset d20 outputs", {done20, ok20, dup20, rng20, miss20}, '0);
    chk("reset d20 lane_ids", lane20, '0);
    rst4 = 0; rst20 = 0;
    @(negedge clk);

    // 4 lanes, ids {2,0,3,1}; bus changes after snapshot must be ignored
    en4 = 1; lock4 = 4'hF; ids4 = 8'h8D;
    repeat (2) @(negedge clk);
    ids4 = 8'h00;
    repeat (3) @(negedge clk);
    chk("t1 no strobe at cycle 5", done4, 0);
    @(negedge clk);
    chk("t1 strobe at cycle 6", done4, 1);
    chk("t1 lane_ids", lane4, 8'h72);
    chk("t1 ok", ok4, 1);
    chk("t1 errors", {dup4, rng4, miss4}, 0);
    @(negedge clk);
    chk("t1 strobe one cycle", done4, 0);
    chk("t1 ok held", ok4, 1);

    // ids {1,1,3,0}: duplicate and missing logical 2
    lock4 = 4'h0;
    @(negedge clk);
    chk("t3 ok cleared by lock drop", ok4, 0);
    lock4 = 4'hF; ids4 = 8'h5C;
    repeat (6) @(negedge clk);
    chk("t3 errors", {dup4, rng4, miss4}, 3'b101);
    chk("t3 no strobe/ok", {done4, ok4}, 0);
    chk("t3 lane_ids kept", lane4, 8'h72);
    repeat (3) @(negedge clk);
    chk("t3 errors held", {dup4, miss4}, 2'b11);
    lock4 = 4'hE;
    @(negedge clk);
    chk("t3 errors cleared", {dup4, rng4, miss4}, 0);

    // abort in BUILD at cnt=2, then relock with {3,2,1,0}
    lock4 = 4'hF; ids4 = 8'h8D;
    repeat (3) @(negedge clk);
    lock4 = 4'h7;
    @(negedge clk);
    lock4 = 4'hF; ids4 = 8'hE4;
    repeat (3) @(negedge clk);
    chk("t5 abort no strobe/errors", {done4, ok4, dup4, rng4, miss4}, 0);
    chk("t5 abort lane_ids kept", lane4, 8'h72);
    repeat (3) @(negedge clk);
    chk("t5 relock strobe", done4, 1);
    chk("t5 relock lane_ids", lane4, 8'hE4);

    // reset during CHECK
    lock4 = 4'h0;
    @(negedge clk);
    lock4 = 4'hF; ids4 = 8'h8D;
    repeat (5) @(negedge clk);
    rst4 = 1;
    @(negedge clk);
    chk("t6 reset outputs", {lane4, done4, ok4, dup4, rng4, miss4}, '0);
    rst4 = 0;
    repeat (6) @(negedge clk);
    chk("t6 rebuild strobe", done4, 1);
    chk("t6 rebuild lane_ids", lane4, 8'h72);

    // 20 lanes, identity
    en20 = 1; lock20 = 20'hFFFFF; ids20 = id_bus;
    repeat (21) @(negedge clk);
    chk("t2 no strobe at cycle 21", done20, 0);
    @(negedge clk);
    chk("t2 strobe at cycle 22", done20, 1);
    chk("t2 identity lane_ids", lane20, id_bus);
    chk("t2 ok", ok20, 1);
    lock20 = 20'hFFFFF & ~(20'h1 << 12);
    @(negedge clk);
    chk("t2 ok cleared by phy7 drop", ok20, 0);
    chk("t2 lane_ids kept", lane20, id_bus);

    // phy 5 reports 25: range + missing
    lock20 = 20'hFFFFF;
    ids20 = id_bus;
    ids20[14*5 +: 5] = 5'd25;
    repeat (22) @(negedge clk);
    chk("t4 errors", {dup20, rng20, miss20}, 3'b011);
    chk("t4 no strobe/ok", {done20, ok20}, 0);
    chk("t4 lane_ids kept", lane20, id_bus);
    lock20 = 20'h0;
    repeat (2) @(negedge clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
